// File: rtl/uart_pixel_loader_if.sv
// Byte stream from the UART receiver in, pixel RAM write port out.
// The loader takes the slave modport; the byte source / RAM side takes the master.
interface uart_pixel_loader_if #(
   parameter int ADDR_W = 5
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_frame_err;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic [2:0]        wr_byte_en;
   logic              wr_en;

   modport master (
      output rx_data, rx_valid, rx_frame_err,
      input  wr_addr, wr_data, wr_byte_en, wr_en
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err,
      output wr_addr, wr_data, wr_byte_en, wr_en
   );
endinterface

// File: rtl/uart_pixel_loader.sv
// Parses UART bytes into pixel RAM writes, resyncing on bad frames and timeouts.
// Optional macro PIXEL_AUTOINC_EN: full RGB writes chain into bursts with an incrementing address.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   S_IDLE    | waiting for a header byte
//   S_GET_R   | full write, waiting for the red byte
//   S_GET_G   | full write, waiting for the green byte
//   S_GET_B   | full write, waiting for the blue byte
//   S_GET_ONE | single-channel write, waiting for its byte
module uart_pixel_loader #(
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int ERR_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   uart_pixel_loader_if.slave bus,
   output logic             busy,
   output logic [ERR_W-1:0] err_count
);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]    TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GET_R   = 3'd1;
   localparam logic [2:0] S_GET_G   = 3'd2;
   localparam logic [2:0] S_GET_B   = 3'd3;
   localparam logic [2:0] S_GET_ONE = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        lane_q;
   logic [7:0]        r_q;
   logic [7:0]        g_q;
   logic [TW-1:0]     timer;
   logic              byte_ok;
   logic              frame_bad;
   logic              hdr_ok;
   logic              tmo;
   logic              tmo_benign;
   logic              err_inc;

   assign busy      = (state != S_IDLE);
   assign byte_ok   = bus.rx_valid & ~bus.rx_frame_err;
   assign frame_bad = bus.rx_valid & bus.rx_frame_err;
   assign hdr_ok    = (bus.rx_data[7:5] == 3'b010) || (bus.rx_data[7:5] == 3'b100) ||
                      (bus.rx_data[7:5] == 3'b101) || (bus.rx_data[7:5] == 3'b110);
   // any rx_valid in the expiry cycle wins over the timeout
   assign tmo       = busy & ~bus.rx_valid & (timer == '0);

`ifdef PIXEL_AUTOINC_EN
   logic fresh_q;
   // a burst that simply stops after a completed pixel is a clean end, not an error
   assign tmo_benign = (state == S_GET_R) & fresh_q;
`else
   assign tmo_benign = 1'b0;
`endif

   assign err_inc = frame_bad | (byte_ok & ~busy & ~hdr_ok) | (tmo & ~tmo_benign);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         addr_q         <= '0;
         lane_q         <= '0;
         r_q            <= '0;
         g_q            <= '0;
         timer          <= '0;
         err_count      <= '0;
         bus.wr_addr    <= '0;
         bus.wr_data    <= '0;
         bus.wr_byte_en <= '0;
         bus.wr_en      <= 1'b0;
`ifdef PIXEL_AUTOINC_EN
         fresh_q        <= 1'b0;
`endif
      end else begin
         bus.wr_en <= 1'b0;

         if (err_inc && (err_count != ERR_MAX))
            err_count <= err_count + ERR_W'(1);

         if (byte_ok)
            timer <= TMO_LOAD;
         else if (busy && (timer != '0))
            timer <= timer - TW'(1);

         if (frame_bad || tmo) begin
            state <= S_IDLE;
         end else if (byte_ok) begin
`ifdef PIXEL_AUTOINC_EN
            fresh_q <= 1'b0;
`endif
            case (state)
               S_IDLE: begin
                  addr_q <= ADDR_W'(bus.rx_data[4:0]);
                  case (bus.rx_data[7:5])
                     3'b010: begin lane_q <= 3'b111; state <= S_GET_R;   end
                     3'b100: begin lane_q <= 3'b100; state <= S_GET_ONE; end
                     3'b101: begin lane_q <= 3'b010; state <= S_GET_ONE; end
                     3'b110: begin lane_q <= 3'b001; state <= S_GET_ONE; end
                     default: state <= S_IDLE;
                  endcase
               end
               S_GET_R: begin
                  r_q   <= bus.rx_data;
                  state <= S_GET_G;
               end
               S_GET_G: begin
                  g_q   <= bus.rx_data;
                  state <= S_GET_B;
               end
               S_GET_B: begin
                  bus.wr_addr    <= addr_q;
                  bus.wr_data    <= {r_q, g_q, bus.rx_data};
                  bus.wr_byte_en <= 3'b111;
                  bus.wr_en      <= 1'b1;
`ifdef PIXEL_AUTOINC_EN
                  addr_q  <= addr_q + ADDR_W'(1);
                  fresh_q <= 1'b1;
                  state   <= S_GET_R;
`else
                  state   <= S_IDLE;
`endif
               end
               S_GET_ONE: begin
                  bus.wr_addr    <= addr_q;
                  bus.wr_data    <= {3{bus.rx_data}};
                  bus.wr_byte_en <= lane_q;
                  bus.wr_en      <= 1'b1;
                  state          <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_pixel_loader.sv
// Randomized scoreboard bench for uart_pixel_loader with a frame-level reference model.
// Honours PIXEL_AUTOINC_EN when the same macro is defined for the build.
module tb_uart_pixel_loader;
   localparam int ADDR_W  = 5;
   localparam int TMO     = 40;
   localparam int ERR_W   = 8;
   localparam int ERR_MAX = 255;
`ifdef PIXEL_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic [ERR_W-1:0] err_count;

   always #5 clk = ~clk;

   uart_pixel_loader_if #(.ADDR_W(ADDR_W)) bus ();

   uart_pixel_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .err_count (err_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [4:0]  addr;
      logic [23:0] data;
      logic [2:0]  be;
   } wr_t;

   wr_t exp_q[$];

   // frame-level reference model
   bit         m_busy;
   int         m_need;
   logic [4:0] m_addr;
   logic [2:0] m_be;
   logic [7:0] m_bytes[$];
   bit         m_burst;
   int         m_err;
   int         m_gap;
   bit         m_wr;

   function void m_reset();
      m_busy = 0; m_need = 0; m_addr = '0; m_be = '0;
      m_bytes.delete(); m_burst = 0; m_err = 0; m_gap = 0; m_wr = 0;
   endfunction

   function void m_err_inc();
      if (m_err < ERR_MAX) m_err++;
   endfunction

   function void m_abort();
      m_busy = 0;
      m_bytes.delete();
      m_burst = 0;
   endfunction

   function void m_gap_add(input int n);
      m_gap += n;
      if (m_busy && m_gap >= TMO) begin
         if (!(AUTOINC && m_burst && m_bytes.size() == 0)) m_err_inc();
         m_abort();
      end
   endfunction

   function void m_byte(input logic [7:0] b, input bit fe);
      wr_t w;
      m_gap = 0;
      m_wr  = 0;
      if (fe) begin
         m_err_inc();
         m_abort();
      end else if (!m_busy) begin
         m_burst = 0;
         m_addr  = b[4:0];
         case (b[7:5])
            3'b010: begin m_busy = 1; m_need = 3; m_be = 3'b111; end
            3'b100: begin m_busy = 1; m_need = 1; m_be = 3'b100; end
            3'b101: begin m_busy = 1; m_need = 1; m_be = 3'b010; end
            3'b110: begin m_busy = 1; m_need = 1; m_be = 3'b001; end
            default: m_err_inc();
         endcase
      end else begin
         m_bytes.push_back(b);
         if (m_bytes.size() == m_need) begin
            w.addr = m_addr;
            w.be   = m_be;
            if (m_need == 3) w.data = {m_bytes[0], m_bytes[1], m_bytes[2]};
            else             w.data = {b, b, b};
            exp_q.push_back(w);
            m_wr = 1;
            m_bytes.delete();
            if (m_need == 3 && AUTOINC) begin
               m_addr  = m_addr + 5'd1;
               m_burst = 1;
            end else begin
               m_busy  = 0;
               m_burst = 0;
            end
         end
      end
   endfunction

   task automatic send(input logic [7:0] b, input bit fe, input int gap);
      if (gap > 0) repeat (gap) @(negedge clk);
      m_gap_add(gap);
      m_byte(b, fe);
      bus.rx_data      = b;
      bus.rx_frame_err = fe;
      bus.rx_valid     = 1'b1;
      @(negedge clk);
      bus.rx_valid     = 1'b0;
      bus.rx_frame_err = 1'b0;
      bus.rx_data      = 8'($urandom);
      check("wr_en_latency", 32'(bus.wr_en), 32'(m_wr));
      check("err_count", 32'(err_count), 32'(m_err));
      check("busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      m_gap_add(n);
      check("idle_busy", 32'(busy), 32'(m_busy));
      check("idle_err_count", 32'(err_count), 32'(m_err));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
      check({tag, "_wr_byte_en"}, 32'(bus.wr_byte_en), 32'd0);
      check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   task automatic check_write(input string tag, input logic [4:0] a, input logic [23:0] d,
                              input logic [2:0] be);
      check({tag, "_addr"}, 32'(bus.wr_addr), 32'(a));
      check({tag, "_data"}, 32'(bus.wr_data), 32'(d));
      check({tag, "_be"}, 32'(bus.wr_byte_en), 32'(be));
   endtask

   // scoreboard monitor: every wr_en pulse must match the oldest expected write
   always @(negedge clk) begin : mon
      wr_t w;
      if (rst === 1'b1 && bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h, expected none",
                     bus.wr_addr, bus.wr_data, bus.wr_byte_en);
         end else begin
            w = exp_q.pop_front();
            check("sb_wr_addr", 32'(bus.wr_addr), 32'(w.addr));
            check("sb_wr_data", 32'(bus.wr_data), 32'(w.data));
            check("sb_wr_byte_en", 32'(bus.wr_byte_en), 32'(w.be));
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   logic [2:0] ops[4];

   initial begin
      ops = '{3'b010, 3'b100, 3'b101, 3'b110};
      m_reset();
      rst              = 1'b0;
      bus.rx_data      = '0;
      bus.rx_valid     = 1'b0;
      bus.rx_frame_err = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // full RGB write
      send(8'h41, 0, 0); send(8'h20, 0, 1); send(8'hC0, 0, 0); send(8'h05, 0, 2);
      check_write("full", 5'd1, 24'h20C005, 3'b111);
      check("full_err", 32'(err_count), 32'd0);
      idle(TMO + 2);

      // single-channel write and output hold
      send(8'hBF, 0, 0); send(8'h7A, 0, 0);
      check_write("single", 5'd31, 24'h7A7A7A, 3'b010);
      idle(5);
      check_write("hold", 5'd31, 24'h7A7A7A, 3'b010);
      check("hold_wr_en", 32'(bus.wr_en), 32'd0);

      // bad opcode, then a good frame
      send(8'hE3, 0, 0);
      check("badop_err", 32'(err_count), 32'd1);
      check("badop_busy", 32'(busy), 32'd0);
      send(8'h43, 0, 0); send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
      check_write("after_badop", 5'd3, 24'h010203, 3'b111);
      idle(TMO + 2);

      // frame error abort
      send(8'h41, 0, 0); send(8'h11, 0, 0); send(8'h55, 1, 0);
      check("fe_err", 32'(err_count), 32'd2);
      check("fe_busy", 32'(busy), 32'd0);

      // timeout abort, one cycle short then expiry
      send(8'h41, 0, 0);
      idle(TMO - 1);
      check("tmo_not_yet", 32'(busy), 32'd1);
      idle(1);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_err", 32'(err_count), 32'd3);

      // byte landing on the expiry cycle is accepted
      send(8'h42, 0, 0); send(8'hAA, 0, TMO - 1); send(8'hBB, 0, 0); send(8'hCC, 0, 0);
      check_write("expiry_edge", 5'd2, 24'hAABBCC, 3'b111);
      check("expiry_edge_err", 32'(err_count), 32'd3);
      idle(TMO + 2);

      // reset mid-frame
      send(8'h41, 0, 0); send(8'h11, 0, 0);
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      m_reset();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(8'h42, 0, 0); send(8'hAA, 0, 0); send(8'hBB, 0, 0); send(8'hCC, 0, 0);
      check_write("post_reset", 5'd2, 24'hAABBCC, 3'b111);
      idle(TMO + 2);

`ifdef PIXEL_AUTOINC_EN
      send(8'h5F, 0, 0);
      send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0);
      check_write("burst0", 5'd31, 24'h010203, 3'b111);
      send(8'h04, 0, 0); send(8'h05, 0, 0); send(8'h06, 0, 0);
      check_write("burst1", 5'd0, 24'h040506, 3'b111);
      check("burst_busy", 32'(busy), 32'd1);
      idle(TMO + 2);
      check("burst_end_busy", 32'(busy), 32'd0);
      check("burst_end_err", 32'(err_count), 32'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         int gap;
         logic [7:0] b;
         bit fe;
         r = $urandom_range(0, 99);
         if (r < 4)      gap = TMO + $urandom_range(0, 2);
         else if (r < 8) gap = TMO - 1;
         else            gap = $urandom_range(0, 3);
         if (!m_busy && $urandom_range(0, 9) < 7)
            b = {ops[$urandom_range(0, 3)], 5'($urandom)};
         else
            b = 8'($urandom);
         fe = ($urandom_range(0, 19) == 0);
         send(b, fe, gap);
      end
      idle(TMO + 2);

      // saturation of the error counter
      for (int i = 0; i < 260; i++) send({3'b111, 5'($urandom)}, 0, 0);
      check("err_saturated", 32'(err_count), 32'd255);
      send(8'hFF, 1, 0);
      check("err_stays_saturated", 32'(err_count), 32'd255);

      idle(3);
      check("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Sits between the UART receiver and the 32-entry x 24-bit pixel RAM write port of the LED matrix top.
- Consumes received bytes and parses them into pixel write commands.
- Drives the RAM write address, data and byte enables, with a one-cycle write strobe.
- Resynchronises on malformed frames, UART framing errors and inter-byte timeouts, and keeps a saturating error count.

Parameters:
- ADDR_W, 5, pixel address width; RAM depth is 2**ADDR_W.
- TIMEOUT_CYCLES, 4096, maximum clk cycles allowed between bytes of one frame; must be >= 2.
- ERR_W, 8, error counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- rx_frame_err  input  1  qualifies rx_valid; 1 = stop bit bad, so the byte is discarded.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  24  {R[23:16], G[15:8], B[7:0]}.
- wr_byte_en  output  3  byte enables; bit2=R, bit1=G, bit0=B.
- wr_en  output  1  one-cycle write strobe.
- busy  output  1  1 while a frame is in progress (state != IDLE).
- err_count  output  ERR_W  saturating count of discarded or aborted frames.

Behaviour:
- Reset:
  - Asserting rst clears all state immediately, mid-frame included; any partial frame is lost.
  - All outputs read 0 and state = IDLE.
- Header byte fields: [7:5] opcode, [4:0] address. Opcodes:
  - 3'b010: full RGB write; three data bytes follow, in the order R, G, B.
  - 3'b100: R-only write; one data byte follows.
  - 3'b101: G-only write; one data byte follows.
  - 3'b110: B-only write; one data byte follows.
  - Any other opcode in IDLE: byte dropped, err_count+1, stay IDLE.
- States: IDLE, GET_R, GET_G, GET_B, GET_ONE.
- Transitions on an accepted byte:
  - IDLE, opcode 010 -> GET_R.
  - IDLE, opcode 10x/110 -> GET_ONE.
  - GET_R -> GET_G -> GET_B.
  - GET_B -> IDLE.
  - GET_ONE -> IDLE.
- Data bytes are taken raw: no opcode check, and bit7 is not special.
- Write output:
  - On the cycle after the last data byte is accepted: wr_en=1 for exactly one cycle.
  - wr_addr = the header address; wr_data carries the assembled bytes.
  - wr_byte_en = 3'b111 for a full write, or one-hot for a single-channel write.
  - For single-channel writes the data byte is replicated into all three lanes.
- Output hold: wr_addr, wr_data and wr_byte_en hold their last values between writes; only wr_en pulses.
- Framing error:
  - rx_valid with rx_frame_err=1 discards the byte in any state.
  - If busy: abort to IDLE, err_count+1.
  - In IDLE: err_count+1.
- Timeout:
  - Counter resets on every accepted byte and counts while busy.
  - On reaching TIMEOUT_CYCLES with no byte: -> IDLE, err_count+1, no write.
  - A byte arriving in the same cycle as expiry is accepted; the timeout does not fire.
- Back-to-back frames: a header arriving on the wr_en cycle is accepted normally. rx_valid is at most one cycle per byte, so there is no conflict.
- err_count saturates at 2**ERR_W-1 and never wraps.

Optional Feature:
- Macro: PIXEL_AUTOINC_EN.
- With the macro:
  - After a full RGB write, GET_B goes to GET_R (not IDLE), with the address incremented modulo 2**ADDR_W (31 wraps to 0).
  - busy stays 1 between pixels; the burst ends only on timeout.
  - A burst-end timeout in GET_R with zero bytes received since the last write is normal termination: -> IDLE with no err_count increment.
  - A timeout mid-pixel still counts as an error.
  - Single-channel opcodes do not auto-increment.
- Without the macro: GET_B always goes to IDLE, as specified above.

Test Plan:
- Full RGB write: bytes 0x41,0x20,0xC0,0x05 -> one wr_en pulse one cycle after 0x05, wr_addr=1, wr_data=24'h20C005, wr_byte_en=3'b111, err_count=0.
- Single-channel write: 0xBF,0x7A -> wr_en pulse, wr_addr=31, wr_data=24'h7A7A7A, wr_byte_en=3'b010.
- Bad opcode: 0xE3 -> no write, err_count=1, busy=0. A following 0x43,1,2,3 then writes addr 3 with data 24'h010203.
- Aborts:
  - 0x41,0x11 followed by a byte with rx_frame_err=1 -> no write, err_count+1.
  - 0x41 followed by TIMEOUT_CYCLES idle cycles -> no write, err_count+1, busy=0.
- Reset mid-frame: after 0x41,0x11, drop rst to 0 -> all outputs 0 immediately. After release, 0x42,0xAA,0xBB,0xCC writes addr 2 with data 24'hAABBCC.
- PIXEL_AUTOINC_EN burst: 0x5F then six data bytes 1..6 -> write addr 31 with data 24'h010203, then addr 0 with data 24'h040506. Idle timeout then -> busy=0 with err_count unchanged.
